// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - circular return-address stack with pending-return misprediction check
// Optional RAS_STATS_EN adds hit_cnt/miss_cnt resolve statistics.
module return_addr_stack #(
   parameter int DEPTH = 8
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic                     push,
   input  logic [31:0]              push_addr,
   input  logic                     pop,
   output logic [31:0]              pred_addr,
   output logic                     pred_valid,
   input  logic                     resolve,
   input  logic [31:0]              resolve_addr,
   output logic                     mispredict,
   input  logic                     flush,
`ifdef RAS_STATS_EN
   output logic [31:0]              hit_cnt,
   output logic [31:0]              miss_cnt,
`endif
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {IDLE, PENDING} pend_state_t;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] tos;
   logic [AW-1:0] tos_inc;
   logic [AW-1:0] tos_dec;
   logic [AW:0]   cnt_r;
   logic          empty;
   logic          full;
   logic          replace_top;
   pend_state_t   state;
   logic [31:0]   pend_addr;
   logic          pend_valid;
   logic          resolve_act;
   logic          miss_now;

   assign tos_inc     = tos + AW'(1);
   assign tos_dec     = tos - AW'(1);
   assign empty       = (cnt_r == '0);
   assign full        = (cnt_r == (AW+1)'(DEPTH));
   // push+pop on a non-empty stack swaps the top in place
   assign replace_top = push && pop && !empty;

   assign pred_addr   = {mem[tos][31:1], 1'b0};
   assign pred_valid  = !empty;
   assign count       = cnt_r;

   // flush cancels the outstanding record even when resolve arrives with it
   assign resolve_act = resolve && (state == PENDING) && !flush;
   assign miss_now    = !pend_valid || (resolve_addr != pend_addr);

   always_ff @(posedge CLK) begin
      if (nRST && push) begin
         if (replace_top)
            mem[tos] <= push_addr;
         else
            mem[tos_inc] <= push_addr;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         tos        <= '0;
         cnt_r      <= '0;
         state      <= IDLE;
         pend_addr  <= '0;
         pend_valid <= 1'b0;
         mispredict <= 1'b0;
`ifdef RAS_STATS_EN
         hit_cnt    <= '0;
         miss_cnt   <= '0;
`endif
      end else begin
         if (push && !replace_top) begin
            tos <= tos_inc;
            if (!full)
               cnt_r <= cnt_r + (AW+1)'(1);
         end else if (pop && !push && !empty) begin
            tos   <= tos_dec;
            cnt_r <= cnt_r - (AW+1)'(1);
         end

         mispredict <= resolve_act && miss_now;

`ifdef RAS_STATS_EN
         if (resolve_act) begin
            if (miss_now)
               miss_cnt <= miss_cnt + 32'd1;
            else
               hit_cnt  <= hit_cnt + 32'd1;
         end
`endif

         // the old record is judged above before a new pop replaces it
         if (pop) begin
            state      <= PENDING;
            pend_addr  <= pred_addr;
            pend_valid <= pred_valid;
         end else if (flush || resolve) begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_return_addr_stack.sv
// tb/tb_return_addr_stack.sv - scoreboard bench for return_addr_stack (RAS_STATS_EN checks when defined)
module tb_return_addr_stack;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        push = 1'b0;
   logic [31:0] push_addr = '0;
   logic        pop = 1'b0;
   logic [31:0] pred_addr;
   logic        pred_valid;
   logic        resolve = 1'b0;
   logic [31:0] resolve_addr = '0;
   logic        mispredict;
   logic        flush = 1'b0;
   logic [3:0]  count;
`ifdef RAS_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   return_addr_stack #(.DEPTH(8)) dut (
      .CLK(CLK), .nRST(nRST), .push(push), .push_addr(push_addr), .pop(pop),
      .pred_addr(pred_addr), .pred_valid(pred_valid), .resolve(resolve),
      .resolve_addr(resolve_addr), .mispredict(mispredict), .flush(flush),
`ifdef RAS_STATS_EN
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
      .count(count)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail = 0;
   logic mon_en = 1'b0;
   logic res_seen = 1'b0;

   logic        mis_q [$];
   string       st_name_q [$];
   int          st_cnt_q [$];
   logic [31:0] st_addr_q [$];
   logic        st_valid_q [$];
   logic        st_chka_q [$];
   string       sx_name_q [$];
   logic [31:0] sx_hit_q [$];
   logic [31:0] sx_miss_q [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic pu, input logic [31:0] pa, input logic po,
                       input logic rs, input logic [31:0] ra, input logic fl, input logic em);
      push = pu; push_addr = pa; pop = po; resolve = rs; resolve_addr = ra; flush = fl;
      if (rs && nRST) mis_q.push_back(em);
      @(posedge CLK);
      #1;
      push = 1'b0; pop = 1'b0; resolve = 1'b0; flush = 1'b0;
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic do_push(input logic [31:0] a);
      step(1'b1, a, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic do_pop();
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic do_resolve(input logic [31:0] a, input logic em);
      step(1'b0, 32'h0, 1'b0, 1'b1, a, 1'b0, em);
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      idle();
      nRST = 1'b1;
   endtask

   task automatic expect_state(input string nm, input int c, input logic [31:0] a,
                               input logic v, input logic ca);
      st_name_q.push_back(nm); st_cnt_q.push_back(c); st_addr_q.push_back(a);
      st_valid_q.push_back(v); st_chka_q.push_back(ca);
   endtask

   task automatic expect_stats(input string nm, input logic [31:0] h, input logic [31:0] m);
      sx_name_q.push_back(nm); sx_hit_q.push_back(h); sx_miss_q.push_back(m);
   endtask

   always @(posedge CLK) res_seen <= resolve && nRST;

   // monitor: mispredict every cycle, queued state/stat expectations as they appear
   always @(negedge CLK) begin
      if (mon_en) begin
         logic  em;
         string nm;
         em = 1'b0;
         if (res_seen) begin
            if (mis_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL mis_q_underflow: got resolve expected none at %0t", $time);
            end else begin
               em = mis_q.pop_front();
            end
         end
         chk(res_seen ? "mispredict_resolve" : "mispredict_quiet", {31'b0, mispredict}, {31'b0, em});
         while (st_name_q.size() > 0) begin
            nm = st_name_q.pop_front();
            chk({nm, "_count"}, {28'b0, count}, st_cnt_q.pop_front());
            chk({nm, "_valid"}, {31'b0, pred_valid}, {31'b0, st_valid_q.pop_front()});
            if (st_chka_q.pop_front())
               chk({nm, "_addr"}, pred_addr, st_addr_q[0]);
            void'(st_addr_q.pop_front());
         end
`ifdef RAS_STATS_EN
         while (sx_name_q.size() > 0) begin
            nm = sx_name_q.pop_front();
            chk({nm, "_hit"}, hit_cnt, sx_hit_q.pop_front());
            chk({nm, "_miss"}, miss_cnt, sx_miss_q.pop_front());
         end
`endif
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not reach end of test");
      $fatal(1);
   end

   initial begin
      @(posedge CLK); #1;
      do_reset();
      mon_en = 1'b1;
      expect_state("reset", 0, 32'h0, 1'b0, 1'b0);
      idle();

      // reset beats concurrent push/pop/resolve with a pending record
      do_push(32'hA0);
      do_pop();
      nRST = 1'b0;
      step(1'b1, 32'hB0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
      nRST = 1'b1;
      expect_state("reset_wins", 0, 32'h0, 1'b0, 1'b0);
      do_resolve(32'h123, 1'b0);
      idle();

      do_push(32'h100); do_push(32'h200); do_push(32'h300);
      expect_state("push3", 3, 32'h300, 1'b1, 1'b1);
      do_push(32'h455);
      expect_state("bit0_clear", 4, 32'h454, 1'b1, 1'b1);
      idle();

      do_reset();
      do_push(32'h100); do_push(32'h200);
      expect_state("two", 2, 32'h200, 1'b1, 1'b1);
      do_pop();
      expect_state("pop1", 1, 32'h100, 1'b1, 1'b1);
      do_resolve(32'h200, 1'b0);
      do_pop();
      expect_state("pop2", 0, 32'h0, 1'b0, 1'b0);
      do_resolve(32'h104, 1'b1);
      idle(); idle();

      // wrap: 9 pushes into 8 entries, pops chained with resolves of the previous record
      do_reset();
      for (int i = 1; i <= 9; i++) do_push(32'(i * 16));
      expect_state("full", 8, 32'h90, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         expect_state("wrap_top", 8 - i, 32'(32'h90 - i * 16), 1'b1, 1'b1);
         if (i == 0)
            do_pop();
         else
            step(1'b0, 32'h0, 1'b1, 1'b1, 32'(32'h90 - (i - 1) * 16), 1'b0, 1'b0);
      end
      expect_state("drained", 0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 1'b0, 1'b0);
      expect_state("pop_empty", 0, 32'h0, 1'b0, 1'b0);
      do_resolve(32'h0, 1'b1);
      idle();

      do_reset();
      do_push(32'h40);
      step(1'b1, 32'h80, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      expect_state("swap_top", 1, 32'h80, 1'b1, 1'b1);
      do_resolve(32'h40, 1'b0);
      idle();

      do_reset();
      do_push(32'h400); do_push(32'h500);
      do_pop();
      expect_state("pre_flush", 1, 32'h400, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b1, 32'h999, 1'b1, 1'b0);
      expect_state("post_flush", 1, 32'h400, 1'b1, 1'b1);
      do_resolve(32'h999, 1'b0);
      idle();

      // statistics: one hit, one miss, one invalid-record miss, one flushed record
      do_reset();
      do_push(32'h10); do_push(32'h20);
      do_pop(); do_resolve(32'h20, 1'b0);
      do_pop(); do_resolve(32'h99, 1'b1);
      do_pop(); do_resolve(32'h0, 1'b1);
      do_pop(); step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
`ifdef RAS_STATS_EN
      expect_stats("stats", 32'd1, 32'd2);
`endif
      idle();
      do_reset();
`ifdef RAS_STATS_EN
      expect_stats("stats_reset", 32'd0, 32'd0);
`endif
      idle(); idle(); idle();

      chk("mis_q_drained", 32'(mis_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
